// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dm_arb_pkg
// Brief   : Shared defaults and types for the data-memory arbiter.
// Revision: 1.0
// ============================================================================
package dm_arb_pkg;

  localparam int c_ADDR_W    = 13;
  localparam int c_DATA_W    = 32;
  localparam int c_MAX_BURST = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/dm_rd_return.sv
`default_nettype none
// ============================================================================
// Module  : dm_rd_return
// Brief   : Two-entry owner-tag pipeline and registered read-data return demux.
// Revision: 1.0
// ============================================================================
module dm_rd_return
  import dm_arb_pkg::*;
#(
  parameter int DATA_W = c_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_issue,
  input  owner_t            i_owner,
  input  logic              i_last,
  input  logic [DATA_W-1:0] i_dm_rdata,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_dma_rvalid,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_dma_rd_done
);

  logic              r_v0;
  owner_t            r_own0;
  logic              r_last0;
  logic              r_v1;
  owner_t            r_own1;
  logic              r_last1;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  // Entry 0 lines up with dm_re; entry 1 lines up with the captured data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0        <= 1'b0;
      r_own0      <= OWN_CPU;
      r_last0     <= 1'b0;
      r_v1        <= 1'b0;
      r_own1      <= OWN_CPU;
      r_last1     <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_v0    <= i_issue;
      r_own0  <= i_owner;
      r_last0 <= i_issue & i_last;
      r_v1    <= r_v0;
      r_own1  <= r_own0;
      r_last1 <= r_last0;
      if (r_v0 && (r_own0 == OWN_CPU)) begin
        r_cpu_rdata <= i_dm_rdata;
      end
      if (r_v0 && (r_own0 == OWN_DMA)) begin
        r_dma_rdata <= i_dm_rdata;
      end
    end
  end

  assign o_cpu_rvalid  = r_v1 && (r_own1 == OWN_CPU);
  assign o_dma_rvalid  = r_v1 && (r_own1 == OWN_DMA);
  assign o_dma_rd_done = r_v1 && (r_own1 == OWN_DMA) && r_last1;
  assign o_cpu_rdata   = r_cpu_rdata;
  assign o_dma_rdata   = r_dma_rdata;

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dm_arbiter
// Brief   : CPU / DMA-burst arbiter and sequencer for the single-port data RAM.
//           Build option DM_ARB_RR_EN: round-robin with CPU slots inside bursts.
// Revision: 1.0
// ============================================================================
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W    = c_ADDR_W,
  parameter int DATA_W    = c_DATA_W,
  parameter int MAX_BURST = c_MAX_BURST
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_cpu_req,
  input  logic                         i_cpu_we,
  input  logic [ADDR_W-1:0]            i_cpu_addr,
  input  logic [DATA_W-1:0]            i_cpu_wdata,
  output logic                         o_cpu_gnt,
  output logic                         o_cpu_rvalid,
  output logic [DATA_W-1:0]            o_cpu_rdata,
  input  logic                         i_dma_req,
  input  logic                         i_dma_we,
  input  logic [ADDR_W-1:0]            i_dma_addr,
  input  logic [$clog2(MAX_BURST)-1:0] i_dma_len,
  input  logic [DATA_W-1:0]            i_dma_wdata,
  output logic                         o_dma_gnt,
  output logic                         o_dma_rvalid,
  output logic [DATA_W-1:0]            o_dma_rdata,
  output logic                         o_dma_done,
  output logic [ADDR_W-1:0]            o_dm_addr,
  output logic                         o_dm_re,
  output logic                         o_dm_we,
  output logic [DATA_W-1:0]            o_dm_wdata,
  input  logic [DATA_W-1:0]            i_dm_rdata
);

  localparam int c_BEAT_W = $clog2(MAX_BURST);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_BEAT_W-1:0] r_beat;
  logic [c_BEAT_W-1:0] r_len;
  logic [ADDR_W-1:0]   r_base;
  logic                r_we;

  logic                w_cpu_gnt;
  logic                w_dma_gnt;
  logic                w_last;
  logic                w_dma_we;
  logic [ADDR_W-1:0]   w_dma_addr;
  logic                w_rd_issue;
  owner_t              w_owner;
  logic                w_rd_done;

  logic                r_dm_re;
  logic                r_dm_we;
  logic [ADDR_W-1:0]   r_dm_addr;
  logic [DATA_W-1:0]   r_dm_wdata;
  logic                r_wr_done;

`ifdef DM_ARB_RR_EN
  logic                r_last_dma;
`endif

  // Grants are suppressed while rst is high so an aborted burst issues nothing.
  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_dma_gnt   = 1'b0;
    w_last      = 1'b0;
    w_state_nxt = r_state;
    w_dma_addr  = i_dma_addr;
    w_dma_we    = i_dma_we;
    if (!rst) begin
      case (r_state)
        IDLE: begin
`ifdef DM_ARB_RR_EN
          if (i_cpu_req && (!i_dma_req || r_last_dma)) begin
            w_cpu_gnt = 1'b1;
          end else if (i_dma_req) begin
            w_dma_gnt = 1'b1;
          end
`else
          if (i_cpu_req) begin
            w_cpu_gnt = 1'b1;
          end else if (i_dma_req) begin
            w_dma_gnt = 1'b1;
          end
`endif
          if (w_dma_gnt) begin
            w_last = (i_dma_len == '0);
            if (!w_last) begin
              w_state_nxt = BURST;
            end
          end
        end
        BURST: begin
          w_dma_addr = r_base + ADDR_W'(r_beat);
          w_dma_we   = r_we;
`ifdef DM_ARB_RR_EN
          if (i_cpu_req && r_last_dma) begin
            w_cpu_gnt = 1'b1;
          end else begin
            w_dma_gnt = 1'b1;
          end
`else
          w_dma_gnt = 1'b1;
`endif
          if (w_dma_gnt) begin
            w_last = (r_beat == r_len);
            if (w_last) begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_len   <= '0;
      r_base  <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_dma_gnt) begin
        r_beat <= w_last ? '0 : r_beat + c_BEAT_W'(1);
      end
      if (w_dma_gnt && (r_state == IDLE)) begin
        r_base <= i_dma_addr;
        r_len  <= i_dma_len;
        r_we   <= i_dma_we;
      end
    end
  end

`ifdef DM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_dma <= 1'b1;
    end else if (w_cpu_gnt) begin
      r_last_dma <= 1'b0;
    end else if (w_dma_gnt) begin
      r_last_dma <= 1'b1;
    end
  end
`endif

  // Without a grant only the strobes drop; address and data hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dm_re    <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
      r_wr_done  <= 1'b0;
    end else begin
      r_wr_done <= w_dma_gnt & w_last & w_dma_we;
      if (w_cpu_gnt) begin
        r_dm_addr  <= i_cpu_addr;
        r_dm_re    <= ~i_cpu_we;
        r_dm_we    <= i_cpu_we;
        r_dm_wdata <= i_cpu_wdata;
      end else if (w_dma_gnt) begin
        r_dm_addr  <= w_dma_addr;
        r_dm_re    <= ~w_dma_we;
        r_dm_we    <= w_dma_we;
        r_dm_wdata <= i_dma_wdata;
      end else begin
        r_dm_re <= 1'b0;
        r_dm_we <= 1'b0;
      end
    end
  end

  assign w_rd_issue = (w_cpu_gnt & ~i_cpu_we) | (w_dma_gnt & ~w_dma_we);
  assign w_owner    = w_cpu_gnt ? OWN_CPU : OWN_DMA;

  dm_rd_return #(
    .DATA_W (DATA_W)
  ) u_rd_return (
    .clk           (clk),
    .rst           (rst),
    .i_issue       (w_rd_issue),
    .i_owner       (w_owner),
    .i_last        (w_last),
    .i_dm_rdata    (i_dm_rdata),
    .o_cpu_rvalid  (o_cpu_rvalid),
    .o_cpu_rdata   (o_cpu_rdata),
    .o_dma_rvalid  (o_dma_rvalid),
    .o_dma_rdata   (o_dma_rdata),
    .o_dma_rd_done (w_rd_done)
  );

  assign o_cpu_gnt  = w_cpu_gnt;
  assign o_dma_gnt  = w_dma_gnt;
  assign o_dma_done = r_wr_done | w_rd_done;
  assign o_dm_addr  = r_dm_addr;
  assign o_dm_re    = r_dm_re;
  assign o_dm_we    = r_dm_we;
  assign o_dm_wdata = r_dm_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dm_arbiter
// Brief   : Directed self-checking bench for dm_arbiter with a negedge RAM model.
// Revision: 1.0
// ============================================================================
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [12:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid, dma_done;
  logic [12:0] dma_addr;
  logic [3:0]  dma_len;
  logic [31:0] dma_wdata, dma_rdata;
  logic [12:0] dm_addr;
  logic        dm_re, dm_we;
  logic [31:0] dm_wdata, dm_rdata;

  int n_err  = 0;
  int n_chk  = 0;
  int n_both = 0;
  bit mem_ready;
  logic [31:0] mem [0:8191];

  always #5 clk = ~clk;

  dm_arbiter u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_cpu_req    (cpu_req),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .o_cpu_gnt    (cpu_gnt),
    .o_cpu_rvalid (cpu_rvalid),
    .o_cpu_rdata  (cpu_rdata),
    .i_dma_req    (dma_req),
    .i_dma_we     (dma_we),
    .i_dma_addr   (dma_addr),
    .i_dma_len    (dma_len),
    .i_dma_wdata  (dma_wdata),
    .o_dma_gnt    (dma_gnt),
    .o_dma_rvalid (dma_rvalid),
    .o_dma_rdata  (dma_rdata),
    .o_dma_done   (dma_done),
    .o_dm_addr    (dm_addr),
    .o_dm_re      (dm_re),
    .o_dm_we      (dm_we),
    .o_dm_wdata   (dm_wdata),
    .i_dm_rdata   (dm_rdata)
  );

  function automatic logic [31:0] pat(input logic [12:0] a);
    return 32'hA500_0000 ^ {19'd0, a};
  endfunction

  // RAM acts on the falling edge; unwritten words read back as pat(addr).
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 8192; i++) mem[i] <= pat(13'(i));
      mem_ready <= 1'b1;
    end else begin
      if (dm_we) mem[dm_addr] <= dm_wdata;
      if (dm_re) dm_rdata <= mem[dm_addr];
    end
    if (dm_re && dm_we) n_both <= n_both + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
  endtask

  task automatic apply_reset();
    step(); rst = 1'b1; idle_inputs();
    step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    repeat (3) step();
    #2;
    n_chk++; if (dm_re !== 1'b0) begin n_err++; $display("FAIL reset_dm_re: got %b want 0", dm_re); end
    n_chk++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL reset_dm_we: got %b want 0", dm_we); end
    n_chk++; if (dm_addr !== 13'd0) begin n_err++; $display("FAIL reset_dm_addr: got %h want 0", dm_addr); end
    n_chk++; if (dm_wdata !== 32'd0) begin n_err++; $display("FAIL reset_dm_wdata: got %h want 0", dm_wdata); end
    n_chk++; if ({cpu_rvalid, dma_rvalid, dma_done} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {cpu_rvalid, dma_rvalid, dma_done}); end
    n_chk++; if (cpu_rdata !== 32'd0 || dma_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h/%h want 0/0", cpu_rdata, dma_rdata); end
    step(); rst = 1'b0;
  endtask

  task automatic test_cpu_rw();
    step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h010; cpu_wdata = 32'h1234_5678;
    #2;
    n_chk++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin n_err++; $display("FAIL cpu_wr_gnt: got cpu=%b dma=%b want 1/0", cpu_gnt, dma_gnt); end
    step(); cpu_we = 1'b0;
    #2;
    n_chk++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL cpu_rd_gnt: got %b want 1", cpu_gnt); end
    n_chk++; if (dm_we !== 1'b1 || dm_re !== 1'b0 || dm_addr !== 13'h010 || dm_wdata !== 32'h1234_5678) begin
      n_err++; $display("FAIL cpu_wr_bus: got we=%b re=%b addr=%h wdata=%h want 1/0/010/12345678", dm_we, dm_re, dm_addr, dm_wdata); end
    step(); cpu_req = 1'b0;
    #2;
    n_chk++; if (dm_re !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 13'h010 || cpu_rvalid !== 1'b0) begin
      n_err++; $display("FAIL cpu_rd_bus: got re=%b we=%b addr=%h rvalid=%b want 1/0/010/0", dm_re, dm_we, dm_addr, cpu_rvalid); end
    step();
    #2;
    n_chk++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1234_5678 || dma_rvalid !== 1'b0) begin
      n_err++; $display("FAIL cpu_rd_data: got rvalid=%b data=%h dma_rvalid=%b want 1/12345678/0", cpu_rvalid, cpu_rdata, dma_rvalid); end
    step();
    #2;
    n_chk++; if (cpu_rvalid !== 1'b0 || dm_re !== 1'b0) begin n_err++; $display("FAIL cpu_rd_after: got rvalid=%b re=%b want 0/0", cpu_rvalid, dm_re); end
  endtask

  task automatic test_dma_wr_burst(input logic [12:0] base, input logic [31:0] d);
    logic [12:0] a;
    logic        exp_g, exp_d;
    step(); dma_req = 1'b1; dma_we = 1'b1; dma_addr = base; dma_len = 4'd3; dma_wdata = d;
    #2;
    n_chk++; if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin n_err++; $display("FAIL dma_wr_gnt0 base=%h: got dma=%b cpu=%b want 1/0", base, dma_gnt, cpu_gnt); end
    for (int k = 1; k <= 5; k++) begin
      step(); dma_req = 1'b0; dma_wdata = d + 32'(k);
      #2;
      if (k <= 4) begin
        a = base + 13'(k - 1);
        n_chk++; if (dm_addr !== a || dm_we !== 1'b1 || dm_re !== 1'b0 || dm_wdata !== d + 32'(k - 1)) begin
          n_err++; $display("FAIL dma_wr_beat%0d: got addr=%h we=%b re=%b wdata=%h want %h/1/0/%h", k - 1, dm_addr, dm_we, dm_re, dm_wdata, a, d + 32'(k - 1)); end
      end
      exp_g = (k < 4);
      exp_d = (k == 4);
      n_chk++; if (dma_gnt !== exp_g) begin n_err++; $display("FAIL dma_wr_gnt cyc%0d base=%h: got %b want %b", k, base, dma_gnt, exp_g); end
      n_chk++; if (dma_done !== exp_d) begin n_err++; $display("FAIL dma_wr_done cyc%0d base=%h: got %b want %b", k, base, dma_done, exp_d); end
    end
    for (int k = 0; k < 4; k++) begin
      a = base + 13'(k);
      n_chk++; if (mem[a] !== d + 32'(k)) begin n_err++; $display("FAIL dma_wr_mem[%h]: got %h want %h", a, mem[a], d + 32'(k)); end
    end
  endtask

  task automatic test_contention();
    apply_reset();
    step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h020;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h100; dma_len = 4'd1;
    #2;
    n_chk++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin n_err++; $display("FAIL cont_c0: got cpu=%b dma=%b want 1/0", cpu_gnt, dma_gnt); end
    step(); cpu_req = 1'b0;
    #2;
    n_chk++; if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || dm_re !== 1'b1 || dm_addr !== 13'h020) begin
      n_err++; $display("FAIL cont_c1: got dma=%b cpu=%b re=%b addr=%h want 1/0/1/020", dma_gnt, cpu_gnt, dm_re, dm_addr); end
    step(); dma_req = 1'b0;
    #2;
    n_chk++; if (dma_gnt !== 1'b1 || dm_addr !== 13'h100 || cpu_rvalid !== 1'b1 || cpu_rdata !== pat(13'h020)) begin
      n_err++; $display("FAIL cont_c2: got dma=%b addr=%h crv=%b crd=%h want 1/100/1/%h", dma_gnt, dm_addr, cpu_rvalid, cpu_rdata, pat(13'h020)); end
    step();
    #2;
    n_chk++; if (dma_gnt !== 1'b0 || dm_addr !== 13'h101 || dma_rvalid !== 1'b1 || dma_rdata !== pat(13'h100) || dma_done !== 1'b0) begin
      n_err++; $display("FAIL cont_c3: got gnt=%b addr=%h rv=%b rd=%h done=%b want 0/101/1/%h/0", dma_gnt, dm_addr, dma_rvalid, dma_rdata, dma_done, pat(13'h100)); end
    step();
    #2;
    n_chk++; if (dma_rvalid !== 1'b1 || dma_rdata !== pat(13'h101) || dma_done !== 1'b1) begin
      n_err++; $display("FAIL cont_c4: got rv=%b rd=%h done=%b want 1/%h/1", dma_rvalid, dma_rdata, dma_done, pat(13'h101)); end
    step();
    #2;
    n_chk++; if (dma_rvalid !== 1'b0 || dma_done !== 1'b0) begin n_err++; $display("FAIL cont_c5: got rv=%b done=%b want 0/0", dma_rvalid, dma_done); end
  endtask

  task automatic test_burst_cpu_held();
    int n_dg, n_drv, n_done, n_cg_mid, first_cg, bad, n_both_gnt;
    int exp_first, exp_mid;
`ifdef DM_ARB_RR_EN
    exp_first = 1;  exp_mid = 15;
`else
    exp_first = 16; exp_mid = 0;
`endif
    n_dg = 0; n_drv = 0; n_done = 0; n_cg_mid = 0; first_cg = -1; bad = 0; n_both_gnt = 0;
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      step();
      if (c == 0) begin
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h200; dma_len = 4'd15;
      end else begin
        dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h050;
      end
      #2;
      if (dma_gnt && cpu_gnt) n_both_gnt++;
      if (cpu_gnt) begin
        if (first_cg < 0) first_cg = c;
        if (n_dg < 16) n_cg_mid++;
      end
      if (dma_gnt) n_dg++;
      if (dma_rvalid) begin
        if (dma_rdata !== pat(13'(32'h200 + n_drv))) bad++;
        n_drv++;
      end
      if (cpu_rvalid && cpu_rdata !== pat(13'h050)) bad++;
      if (dma_done) n_done++;
    end
    cpu_req = 1'b0;
    step(); step(); step();
    n_chk++; if (n_dg !== 16) begin n_err++; $display("FAIL held_dma_gnts: got %0d want 16", n_dg); end
    n_chk++; if (n_drv !== 16) begin n_err++; $display("FAIL held_dma_rvalids: got %0d want 16", n_drv); end
    n_chk++; if (bad !== 0) begin n_err++; $display("FAIL held_data: got %0d bad beats want 0", bad); end
    n_chk++; if (n_done !== 1) begin n_err++; $display("FAIL held_done: got %0d pulses want 1", n_done); end
    n_chk++; if (first_cg !== exp_first) begin n_err++; $display("FAIL held_first_cpu_gnt: got cycle %0d want %0d", first_cg, exp_first); end
    n_chk++; if (n_cg_mid !== exp_mid) begin n_err++; $display("FAIL held_cpu_in_burst: got %0d want %0d", n_cg_mid, exp_mid); end
    n_chk++; if (n_both_gnt !== 0) begin n_err++; $display("FAIL held_dual_gnt: got %0d want 0", n_both_gnt); end
  endtask

  task automatic test_reset_mid_burst();
    int n_rv, n_done, n_dg, bad;
    apply_reset();
    step(); dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h300; dma_len = 4'd15;
    for (int c = 1; c <= 4; c++) begin step(); dma_req = 1'b0; end
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    #2;
    n_chk++; if (dm_re !== 1'b0 || dma_rvalid !== 1'b0 || dma_done !== 1'b0) begin
      n_err++; $display("FAIL rstmid_after: got re=%b rv=%b done=%b want 0/0/0", dm_re, dma_rvalid, dma_done); end
    n_rv = 0; n_done = 0;
    for (int c = 0; c < 8; c++) begin
      step(); #2;
      if (dma_rvalid) n_rv++;
      if (dma_done || dma_gnt || dm_re) n_done++;
    end
    n_chk++; if (n_rv !== 0 || n_done !== 0) begin n_err++; $display("FAIL rstmid_quiet: got rvalids=%0d activity=%0d want 0/0", n_rv, n_done); end
    n_rv = 0; n_done = 0; n_dg = 0; bad = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) begin dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h040; dma_len = 4'd1; end
      else dma_req = 1'b0;
      #2;
      if (dma_gnt) n_dg++;
      if (dma_rvalid) begin
        if (dma_rdata !== pat(13'(32'h040 + n_rv))) bad++;
        n_rv++;
      end
      if (dma_done) n_done++;
    end
    n_chk++; if (n_dg !== 2 || n_rv !== 2 || bad !== 0 || n_done !== 1) begin
      n_err++; $display("FAIL rstmid_restart: got gnts=%0d rvalids=%0d bad=%0d done=%0d want 2/2/0/1", n_dg, n_rv, bad, n_done); end
  endtask

  task automatic test_invariant();
    n_chk++; if (n_both !== 0) begin n_err++; $display("FAIL re_we_exclusive: got %0d cycles with both high want 0", n_both); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_rw();
    test_dma_wr_burst(13'h03FE, 32'hD000_0000);
    test_dma_wr_burst(13'h1FFE, 32'hE000_0000);
    test_contention();
    test_burst_cpu_held();
    test_reset_mid_burst();
    test_invariant();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
